req_capture: RTL and testbench
==============================

# req_capture

Upstream request-capture and service stage for the 8-to-3 priority encoder. It synchronises eight asynchronous request lines and latches their rising edges into a pending vector. It drives that vector and the encoder's active-low enable, then turns the encoder's combinational index/Done result into a registered grant with a valid/ack handshake. A serviced request is cleared on ack, or on timeout if no ack arrives.

## Interface

- `N`, 8: request width. Must equal the encoder input width; only 8 is supported.
- `TIMEOUT`, 16: maximum number of GRANT cycles before forced clear. Must be at least 2.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset is synchronous and active-high.
- `req_in` in 8: raw asynchronous request lines, level-high.
- `enc_y` in 3: encoder index output Y.
- `enc_done` in 1: encoder Done output.
- `pend` out 8: registered pending vector, wired to encoder IN.
- `enc_en_n` out 1: encoder EN, active low.
- `grant_valid` out 1: a grant is being presented.
- `grant_idx` out 3: granted request index, registered.
- `grant_ack` in 1: downstream has accepted the grant.
- `overrun` out 1: sticky; an edge arrived on a bit that was already pending.
- `timeout` out 1: sticky; a grant was force-cleared without ack.

## Operation

- **Synchroniser.** Per bit: `s1 <- req_in`, `s2 <- s1`, `s3 <- s2`. Rising edge `rise[i] = s2[i] & ~s3[i]`.
  - All sync flops reset to 0, so a line held high across reset release registers exactly one request.
- **Pending update**, applied every edge per bit: `pend[i] <- rise[i] | (pend[i] & ~clr[i])`.
  - `clr` is one-hot at `grant_idx` on the cycle a grant retires.
  - When set and clear hit the same bit in the same cycle, set wins.
- **Overrun.** Set when `rise[i] & pend[i] & ~clr[i]` for any i. Cleared only by `rst`.
- **FSM states.** IDLE and GRANT. `enc_en_n` = 0 in IDLE and 1 in GRANT; it is a decoded state output, not a separate flop.
- **IDLE.**
  - The encoder is enabled and sees `pend`.
  - If `enc_done` = 1: `grant_idx <- enc_y`, counter cleared, go to GRANT.
  - Otherwise stay in IDLE.
  - The lowest set index wins, because priority is the encoder's.
- **GRANT.**
  - `grant_valid` = 1, and `grant_idx` is stable.
  - The counter increments each cycle.
  - If `grant_ack` = 1: clear `pend[grant_idx]`, go to IDLE.
  - Else if the counter equals `TIMEOUT-1`: clear `pend[grant_idx]`, set `timeout`, go to IDLE.
  - Ack in the timeout cycle takes precedence, and `timeout` is not set.
- **Encoder interaction.** The encoder is disabled in GRANT, so `enc_done` is ignored there. New edges still accumulate into `pend` during GRANT.
- **Counter width.** `$clog2(TIMEOUT)` bits. It never wraps, because it is cleared on entry to GRANT.

## Timing

- **Reset values** (all registers): `pend`=0, state=IDLE, `enc_en_n`=0, `grant_valid`=0, `grant_idx`=0, `overrun`=0, `timeout`=0, counter=0, sync flops=0.
- **Reset mid-operation.** `rst` high in any cycle forces reset values at the next edge.
  - An outstanding grant is dropped and its pend bit is lost.
  - `rst` overrides all other updates.
- **Edge-to-pend latency.** If `req_in[i]` is first sampled high at edge k, `pend[i]` is 1 after edge k+2.
- **Pend-to-grant latency.** `grant_valid` rises 1 edge after `pend` becomes non-zero in IDLE, because `enc_done` is combinational from `pend`.
- **Grant with same-cycle ack.** `grant_ack` high in the first GRANT cycle gives `grant_valid` for exactly 1 cycle.
  - The next grant can appear 2 cycles after the previous one.
  - Minimum spacing is 2 cycles per grant.
- **Ack rules.** `grant_ack` is sampled only while `grant_valid`=1; ack outside GRANT is ignored.
- **Timeout latency.** With no ack, `grant_valid` lasts exactly `TIMEOUT` cycles and `timeout` is 1 from the following cycle onward.

## Test plan

- Reset, then `req_in`=8'h00 for 20 cycles: `pend`=0, `grant_valid`=0, `enc_en_n`=0, both flags 0.
- Pulse `req_in[5]` for 1 cycle, ack is always high: `pend`=8'h20 after 3 edges; `grant_valid`=1 with `grant_idx`=5 for 1 cycle; then `pend`=0.
- Raise `req_in[6]`, `req_in[2]` and `req_in[0]` in the same cycle, ack is always high:
  - `pend` = 8'h45.
  - Grants appear in order 0, 2, 6, each 2 cycles apart.
  - `pend` ends at 0.
- Pend bit 3, hold ack low with `TIMEOUT`=16: `grant_valid` high for 16 cycles; then `pend[3]`=0 and `timeout`=1 (sticky).
- Pend bit 4 and hold ack low, then re-edge `req_in[4]` during GRANT:
  - `overrun`=1.
  - If the second rise lands in the ack cycle, `pend[4]` stays 1 and is re-granted next.
- Assert `rst` for 1 cycle during GRANT with `pend`=8'h81: all outputs return to reset values at the next edge, and no grant completes.

Source files
------------

// File: rtl/req_capture.sv
// Request capture and service stage in front of the 8-to-3 priority encoder.
// Synchronises request lines, latches rising edges into pend, and turns encoder results into a registered grant.
module req_capture #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic [2:0]   enc_y,
  input  logic         enc_done,
  output logic [N-1:0] pend,
  output logic         enc_en_n,
  output logic         grant_valid,
  output logic [2:0]   grant_idx,
  input  logic         grant_ack,
  output logic         overrun,
  output logic         timeout
);

  // state | meaning
  // IDLE  | encoder enabled, waiting for a pending request
  // GRANT | grant presented, waiting for ack or timeout
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int CW = $clog2(TIMEOUT);

  state_t          state, state_nxt;
  logic [N-1:0]    s1, s2, s3;
  logic [N-1:0]    rise, clr;
  logic [CW-1:0]   cnt;
  logic            retire, tmo_hit, take;

  assign rise        = s2 & ~s3;
  assign enc_en_n    = (state == GRANT);
  assign grant_valid = (state == GRANT);

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    tmo_hit   = 1'b0;
    take      = 1'b0;
    clr       = '0;
    case (state)
      IDLE: begin
        if (enc_done) begin
          take      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // An ack in the last allowed cycle wins over the timeout.
        if (grant_ack) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          retire    = 1'b1;
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
    if (retire) clr = N'(1) << grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      pend      <= '0;
      state     <= IDLE;
      grant_idx <= '0;
      cnt       <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      s1    <= req_in;
      s2    <= s1;
      s3    <= s2;
      // A new edge on the bit being retired keeps it pending.
      pend  <= rise | (pend & ~clr);
      state <= state_nxt;
      if (|(rise & pend & ~clr)) overrun <= 1'b1;
      if (tmo_hit) timeout <= 1'b1;
      if (take) begin
        grant_idx <= enc_y;
        cnt       <= '0;
      end else if (state == GRANT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_req_capture.sv
// Bench for req_capture: models the 8-to-3 encoder, scoreboards grant indices,
// and walks a vector table plus hand-written timeout/overrun/reset sequences.
module tb_req_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [2:0] enc_y;
  logic       enc_done;
  logic [7:0] pend;
  logic       enc_en_n;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       grant_ack;
  logic       overrun;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic prev_gv = 1'b0;

  logic [2:0] exp_q[$];
  int         starts[$];

  typedef struct {
    logic [7:0] req;
    logic [7:0] exp_pend;
    int         exp_grants;
  } vec_t;
  vec_t vecs[6];

  req_capture #(.N(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .enc_y(enc_y), .enc_done(enc_done),
    .pend(pend), .enc_en_n(enc_en_n), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .grant_ack(grant_ack), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Encoder model: lowest set bit wins, outputs forced low when disabled.
  always_comb begin
    enc_done = 1'b0;
    enc_y    = 3'd0;
    if (!enc_en_n) begin
      for (int i = 7; i >= 0; i--) begin
        if (pend[i]) begin
          enc_done = 1'b1;
          enc_y    = 3'(i);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant monitor: every new grant must match the head of the expected queue.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (grant_valid && !prev_gv) begin
      starts.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'(grant_idx), 32'hFFFF);
      end else begin
        chk("grant_idx", 32'(grant_idx), 32'(exp_q.pop_front()));
      end
    end
    prev_gv <= grant_valid;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] v);
    req_in = v;
    @(negedge clk);
    req_in = 8'h00;
  endtask

  task automatic wait_gv(input string name);
    int k;
    k = 0;
    while (!grant_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(grant_valid), 32'd1);
  endtask

  initial begin
    vecs[0] = '{req: 8'h20, exp_pend: 8'h20, exp_grants: 1};
    vecs[1] = '{req: 8'h45, exp_pend: 8'h45, exp_grants: 3};
    vecs[2] = '{req: 8'h01, exp_pend: 8'h01, exp_grants: 1};
    vecs[3] = '{req: 8'h80, exp_pend: 8'h80, exp_grants: 1};
    vecs[4] = '{req: 8'hFF, exp_pend: 8'hFF, exp_grants: 8};
    vecs[5] = '{req: 8'h18, exp_pend: 8'h18, exp_grants: 2};

    rst = 1'b1; req_in = 8'h00; grant_ack = 1'b0;
    cycles(3);
    rst = 1'b0;

    // Quiet idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {pend, enc_en_n, grant_valid, overrun, timeout}, 32'h0);
    end

    // Table of request bursts with ack held high.
    grant_ack = 1'b1;
    foreach (vecs[v]) begin
      starts.delete();
      for (int b = 0; b < 8; b++) if (vecs[v].req[b]) exp_q.push_back(3'(b));
      pulse(vecs[v].req);
      cycles(2);
      chk("pend_latched", 32'(pend), 32'(vecs[v].exp_pend));
      cycles(25);
      chk("pend_drained", 32'(pend), 32'h0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("grant_count", 32'(starts.size()), 32'(vecs[v].exp_grants));
      for (int i = 1; i < starts.size(); i++)
        chk("grant_spacing", 32'(starts[i] - starts[i-1]), 32'd2);
    end
    chk("flags_clean", {30'd0, overrun, timeout}, 32'h0);

    // Timeout: no ack, grant lasts exactly TIMEOUT cycles.
    grant_ack = 1'b0;
    exp_q.push_back(3'd3);
    pulse(8'h08);
    wait_gv("tmo_grant_seen");
    begin
      int n;
      n = 0;
      do begin
        n++;
        @(negedge clk);
      end while (grant_valid && n < 40);
      chk("tmo_grant_len", 32'(n), 32'd16);
    end
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_pend_clr", 32'(pend), 32'h0);
    cycles(5);
    chk("tmo_sticky", 32'(timeout), 32'd1);

    // Second edge landing in the ack cycle: set wins, no overrun, re-grant.
    exp_q.push_back(3'd4);
    pulse(8'h10);
    wait_gv("ovr_grant_seen");
    exp_q.push_back(3'd4);
    req_in = 8'h10;
    @(negedge clk);
    req_in = 8'h00;
    @(negedge clk);
    grant_ack = 1'b1;
    @(negedge clk);
    grant_ack = 1'b0;
    chk("ackcoll_pend", 32'(pend), 32'h10);
    chk("ackcoll_idle", 32'(grant_valid), 32'd0);
    chk("ackcoll_no_ovr", 32'(overrun), 32'd0);
    wait_gv("regrant_seen");

    // Second edge while still pending and not acked: overrun.
    pulse(8'h10);
    cycles(2);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_pend", 32'(pend), 32'h10);
    grant_ack = 1'b1;
    cycles(4);
    chk("ovr_drained", 32'(pend), 32'h0);
    chk("ovr_queue", 32'(exp_q.size()), 32'd0);

    // Reset during a grant with pend = 81.
    grant_ack = 1'b0;
    exp_q.push_back(3'd0);
    pulse(8'h81);
    wait_gv("rst_grant_seen");
    chk("rst_pre_pend", 32'(pend), 32'h81);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs", {pend, enc_en_n, grant_valid, grant_idx, overrun, timeout}, 32'h0);
    grant_ack = 1'b1;
    cycles(20);
    chk("rst_no_grant", 32'(pend), 32'h0);

    // Line held high across reset release gives exactly one request.
    req_in = 8'h02;
    rst = 1'b1;
    cycles(3);
    exp_q.push_back(3'd1);
    rst = 1'b0;
    cycles(15);
    req_in = 8'h00;
    cycles(5);
    chk("held_queue", 32'(exp_q.size()), 32'd0);
    chk("held_pend", 32'(pend), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
